router_pkt_ctrl_fsm: RTL and testbench
======================================

Name: router_pkt_ctrl_fsm

Overview:
- Moore control FSM for a 1x3 packet router (one input, three output FIFOs).
- Decodes the 2-bit destination address in the header byte and sequences header, payload and parity loading into the router's register/FIFO datapath.
- Stalls on a full FIFO and waits for a busy destination FIFO to drain.
- Drives the datapath strobes and the upstream busy flag.

Parameters:
- None. The state encoding is internal: 8 states, 3-bit binary.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  reset, synchronous and active-low.
- pkt_valid  in  1  high while the source is driving header/payload bytes.
- fifo_full  in  1  full flag of the currently addressed FIFO (muxed externally).
- fifo_empty_0, fifo_empty_1, fifo_empty_2  in  1 each  empty flags of FIFOs 0, 1 and 2.
- soft_reset_0, soft_reset_1, soft_reset_2  in  1 each  per-FIFO read-timeout soft resets.
- parity_done  in  1  datapath has registered the parity byte.
- low_packet_valid  in  1  datapath saw pkt_valid fall while the FSM was stalled.
- data_in  in  2  address field, i.e. header bits [1:0].
- write_enb_reg  out  1  write enable into the addressed FIFO.
- detect_add  out  1  FSM is in DECODE_ADDRESS.
- lfd_state  out  1  FSM is in LOAD_FIRST_DATA (header write).
- ld_state  out  1  FSM is in LOAD_DATA.
- laf_state  out  1  FSM is in LOAD_AFTER_FULL.
- full_state  out  1  FSM is in FIFO_FULL_STATE.
- rst_int_reg  out  1  FSM is in CHECK_PARITY_ERROR; clears the internal parity registers.
- busy  out  1  router cannot accept a new byte.

Behaviour:
- Reset: resetn=0 sampled at a rising edge puts the FSM in DECODE_ADDRESS and clears the address latch to 0.
  - Output values after reset: detect_add=1, all other outputs 0.
- Address latch: in DECODE_ADDRESS with pkt_valid=1, data_in is captured into a 2-bit register (addr_q).
- Transitions (evaluated every rising edge):
  - DECODE_ADDRESS:
    - pkt_valid=1 and data_in=N (N in 0..2) with fifo_empty_N=1: go to LOAD_FIRST_DATA.
    - pkt_valid=1 and data_in=N with fifo_empty_N=0: go to WAIT_TILL_EMPTY.
    - pkt_valid=0, or data_in=3 (invalid address): stay.
  - LOAD_FIRST_DATA: go to LOAD_DATA unconditionally (exactly 1 cycle).
  - LOAD_DATA:
    - fifo_full=1: go to FIFO_FULL_STATE.
    - else pkt_valid=0: go to LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: fifo_full=0 goes to LOAD_AFTER_FULL; otherwise stay.
  - LOAD_AFTER_FULL:
    - parity_done=1: go to DECODE_ADDRESS.
    - else low_packet_valid=1: go to LOAD_PARITY.
    - else go to LOAD_DATA.
  - LOAD_PARITY: go to CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full=1 goes to FIFO_FULL_STATE; otherwise DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty_[addr_q]=1 goes to LOAD_FIRST_DATA; otherwise stay. The address is taken from addr_q, not the live data_in.
- Soft reset:
  - soft_reset_[addr_q]=1 (with resetn=1) forces DECODE_ADDRESS from any state.
  - Soft resets of the non-addressed FIFOs are ignored.
  - resetn has priority over soft reset.
- Outputs are decoded from the current state only (Moore; no combinational path from inputs):
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = LOAD_FIRST_DATA | LOAD_PARITY | FIFO_FULL_STATE | LOAD_AFTER_FULL | WAIT_TILL_EMPTY | CHECK_PARITY_ERROR.
  - busy=0 only in DECODE_ADDRESS and LOAD_DATA.
  - Each of the single-state flags (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) is high in exactly one state.
- Unused state encodings recover to DECODE_ADDRESS on the next edge.

Optional Feature:
- Macro: ROUTER_FSM_SOFT_RESET_ANY_EN.
- When defined: any of soft_reset_0/1/2 forces DECODE_ADDRESS, regardless of addr_q.
- When undefined: only soft_reset_[addr_q] acts (the default behaviour above).

Test Plan:
- Reset: hold resetn=0 for 1 edge, then release. Required: detect_add=1, busy=0, all other outputs 0.
- Short packet to port 0: pkt_valid=1, data_in=0, fifo_empty_0=1 for 2 edges, then pkt_valid=0, fifo_full=0.
  - Required state sequence: LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, CHECK_PARITY_ERROR (rst_int_reg=1 for 1 cycle), DECODE_ADDRESS.
- Full stall on port 1: data_in=1, fifo_empty_1=1; assert fifo_full=1 in LOAD_DATA; drop it 1 cycle later; then parity_done=1.
  - Required: full_state=1 with busy=1 during the stall, then laf_state=1 with write_enb_reg=1, then DECODE_ADDRESS.
- Stall then low_packet_valid on port 2: data_in=2, fifo_full pulsed, parity_done=0, low_packet_valid=1.
  - Required: LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS.
  - Repeat with low_packet_valid=0: required LOAD_AFTER_FULL returns to LOAD_DATA.
- Busy destination: data_in=1, fifo_empty_1=0, pkt_valid=1.
  - Required: WAIT_TILL_EMPTY with busy=1; change data_in to 0 and confirm it stays.
  - Then set fifo_empty_1=1: required LOAD_FIRST_DATA next edge.
- Soft reset: in LOAD_DATA with addr_q=0, pulse soft_reset_1.
  - Required: no effect (macro undefined); with the macro defined, DECODE_ADDRESS.
  - Then pulse soft_reset_0: required DECODE_ADDRESS next edge. Also pulse resetn=0 in FIFO_FULL_STATE: required DECODE_ADDRESS.

Source files
------------

// File: rtl/router_pkt_ctrl_fsm_if.sv
// Handshake and strobe bundle between the packet-router control FSM and its
// source/datapath side. The FSM connects through the slave modport.
interface router_pkt_ctrl_fsm_if;
    logic       pkt_valid;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       busy;

    modport master (
        output pkt_valid, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2, parity_done,
               low_packet_valid, data_in,
        input  write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2, parity_done,
               low_packet_valid, data_in,
        output write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, busy
    );
endinterface

// File: rtl/router_pkt_ctrl_fsm.sv
// Moore control FSM for a 1x3 packet router: address decode, header/payload/parity
// sequencing, full-FIFO stall. Define ROUTER_FSM_SOFT_RESET_ANY_EN to let any soft reset abort.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header with a valid address
// LOAD_FIRST_DATA    | header byte written into the addressed FIFO
// LOAD_DATA          | payload bytes streaming in
// WAIT_TILL_EMPTY    | destination FIFO still holds an old packet
// FIFO_FULL_STATE    | stalled on a full destination FIFO
// LOAD_AFTER_FULL    | replaying the byte held during the stall
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | parity registers cleared, packet closed
module router_pkt_ctrl_fsm (
    input  logic                      clock,
    input  logic                      resetn,
    router_pkt_ctrl_fsm_if.slave      bus
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [1:0] addr_q;
    logic       soft_hit;
    logic       empty_live;
    logic       empty_held;

    always_comb begin
`ifdef ROUTER_FSM_SOFT_RESET_ANY_EN
        soft_hit = bus.soft_reset_0 | bus.soft_reset_1 | bus.soft_reset_2;
`else
        soft_hit = (addr_q == 2'd0 && bus.soft_reset_0) ||
                   (addr_q == 2'd1 && bus.soft_reset_1) ||
                   (addr_q == 2'd2 && bus.soft_reset_2);
`endif
        empty_live = (bus.data_in == 2'd0 && bus.fifo_empty_0) ||
                     (bus.data_in == 2'd1 && bus.fifo_empty_1) ||
                     (bus.data_in == 2'd2 && bus.fifo_empty_2);
        // WAIT_TILL_EMPTY watches the latched address, not whatever is on data_in now
        empty_held = (addr_q == 2'd0 && bus.fifo_empty_0) ||
                     (addr_q == 2'd1 && bus.fifo_empty_1) ||
                     (addr_q == 2'd2 && bus.fifo_empty_2);

        nxt = DECODE_ADDRESS;
        case (state)
            DECODE_ADDRESS:
                if (bus.pkt_valid && bus.data_in != 2'd3)
                    nxt = empty_live ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                else
                    nxt = DECODE_ADDRESS;
            LOAD_FIRST_DATA:    nxt = LOAD_DATA;
            LOAD_DATA:
                if (bus.fifo_full)       nxt = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) nxt = LOAD_PARITY;
                else                     nxt = LOAD_DATA;
            FIFO_FULL_STATE:    nxt = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (bus.parity_done)           nxt = DECODE_ADDRESS;
                else if (bus.low_packet_valid) nxt = LOAD_PARITY;
                else                           nxt = LOAD_DATA;
            LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:    nxt = empty_held ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            default:            nxt = DECODE_ADDRESS;
        endcase
        if (soft_hit)
            nxt = DECODE_ADDRESS;
    end

    // Outputs are decoded from the next state so they are registered yet stay Moore.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state             <= DECODE_ADDRESS;
            addr_q            <= 2'd0;
            bus.write_enb_reg <= 1'b0;
            bus.detect_add    <= 1'b1;
            bus.lfd_state     <= 1'b0;
            bus.ld_state      <= 1'b0;
            bus.laf_state     <= 1'b0;
            bus.full_state    <= 1'b0;
            bus.rst_int_reg   <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            state <= nxt;
            if (state == DECODE_ADDRESS && bus.pkt_valid)
                addr_q <= bus.data_in;
            bus.write_enb_reg <= (nxt == LOAD_DATA) || (nxt == LOAD_PARITY) ||
                                 (nxt == LOAD_AFTER_FULL);
            bus.detect_add    <= (nxt == DECODE_ADDRESS);
            bus.lfd_state     <= (nxt == LOAD_FIRST_DATA);
            bus.ld_state      <= (nxt == LOAD_DATA);
            bus.laf_state     <= (nxt == LOAD_AFTER_FULL);
            bus.full_state    <= (nxt == FIFO_FULL_STATE);
            bus.rst_int_reg   <= (nxt == CHECK_PARITY_ERROR);
            bus.busy          <= !((nxt == DECODE_ADDRESS) || (nxt == LOAD_DATA));
        end
    end
endmodule

// File: tb/tb_router_pkt_ctrl_fsm.sv
// Scoreboard bench for router_pkt_ctrl_fsm: stimulus queues the expected output
// vector per edge, a negedge monitor pops and compares.
module tb_router_pkt_ctrl_fsm;
    logic clock = 1'b0;
    logic resetn;
    router_pkt_ctrl_fsm_if bus ();

    router_pkt_ctrl_fsm dut (.clock(clock), .resetn(resetn), .bus(bus));

    always #5 clock = ~clock;

    // {write_enb_reg, detect_add, lfd, ld, laf, full, rst_int_reg, busy}
    localparam logic [7:0] O_DA  = 8'b0100_0000;
    localparam logic [7:0] O_LFD = 8'b0010_0001;
    localparam logic [7:0] O_LD  = 8'b1001_0000;
    localparam logic [7:0] O_LAF = 8'b1000_1001;
    localparam logic [7:0] O_FUL = 8'b0000_0101;
    localparam logic [7:0] O_LP  = 8'b1000_0001;
    localparam logic [7:0] O_CPE = 8'b0000_0011;
    localparam logic [7:0] O_WTE = 8'b0000_0001;

    typedef struct {
        logic [7:0] exp;
        int         id;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    step_id = 0;

    task automatic step(input logic [7:0] exp);
        item_t it;
        @(posedge clock);
        it.exp = exp;
        it.id  = step_id;
        sb.push_back(it);
        step_id++;
        #1;
    endtask

    initial begin : monitor
        item_t      it;
        logic [7:0] act;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                act = {bus.write_enb_reg, bus.detect_add, bus.lfd_state, bus.ld_state,
                       bus.laf_state, bus.full_state, bus.rst_int_reg, bus.busy};
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL step%0d outputs: got %b expected %b", it.id, act, it.exp);
                end
            end
        end
    end

    initial begin : stim
        resetn = 1'b0;
        bus.pkt_valid = 1'b0;     bus.fifo_full = 1'b0;
        bus.fifo_empty_0 = 1'b1;  bus.fifo_empty_1 = 1'b1; bus.fifo_empty_2 = 1'b1;
        bus.soft_reset_0 = 1'b0;  bus.soft_reset_1 = 1'b0; bus.soft_reset_2 = 1'b0;
        bus.parity_done = 1'b0;   bus.low_packet_valid = 1'b0;
        bus.data_in = 2'd0;

        step(O_DA);
        resetn = 1'b1;
        step(O_DA);
        bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
        step(O_DA);

        // short packet to port 0
        bus.data_in = 2'd0;
        step(O_LFD); step(O_LD);
        bus.pkt_valid = 1'b0;
        step(O_LP); step(O_CPE); step(O_DA);

        // full stall on port 1, parity already done
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
        step(O_LFD); step(O_LD);
        bus.fifo_full = 1'b1;
        step(O_FUL); step(O_FUL);
        bus.fifo_full = 1'b0; bus.parity_done = 1'b1;
        step(O_LAF);
        bus.pkt_valid = 1'b0;
        step(O_DA);
        bus.parity_done = 1'b0;

        // stall then low_packet_valid on port 2
        bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
        step(O_LFD); step(O_LD);
        bus.fifo_full = 1'b1;
        step(O_FUL);
        bus.fifo_full = 1'b0; bus.low_packet_valid = 1'b1;
        step(O_LAF);
        bus.pkt_valid = 1'b0;
        step(O_LP); step(O_CPE); step(O_DA);
        bus.low_packet_valid = 1'b0;

        // stall, resume into LOAD_DATA, then full during CHECK_PARITY_ERROR
        bus.pkt_valid = 1'b1;
        step(O_LFD); step(O_LD);
        bus.fifo_full = 1'b1;
        step(O_FUL);
        bus.fifo_full = 1'b0;
        step(O_LAF); step(O_LD);
        bus.pkt_valid = 1'b0;
        step(O_LP); step(O_CPE);
        bus.fifo_full = 1'b1;
        step(O_FUL);
        bus.fifo_full = 1'b0; bus.parity_done = 1'b1;
        step(O_LAF); step(O_DA);
        bus.parity_done = 1'b0;

        // busy destination: wait on latched address
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1; bus.fifo_empty_1 = 1'b0;
        step(O_WTE);
        bus.data_in = 2'd0;
        step(O_WTE); step(O_WTE);
        bus.fifo_empty_1 = 1'b1;
        step(O_LFD); step(O_LD);
        bus.pkt_valid = 1'b0;
        step(O_LP); step(O_CPE); step(O_DA);

        // soft resets with addr_q = 0
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
        step(O_LFD); step(O_LD);
        bus.soft_reset_1 = 1'b1;
`ifdef ROUTER_FSM_SOFT_RESET_ANY_EN
        step(O_DA);
        bus.soft_reset_1 = 1'b0;
        step(O_LFD); step(O_LD);
`else
        step(O_LD);
        bus.soft_reset_1 = 1'b0;
        step(O_LD);
`endif
        bus.soft_reset_0 = 1'b1;
        step(O_DA);
        bus.soft_reset_0 = 1'b0; bus.pkt_valid = 1'b0;
        step(O_DA);

        // sync reset wins while stalled
        bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
        step(O_LFD); step(O_LD);
        bus.fifo_full = 1'b1;
        step(O_FUL);
        resetn = 1'b0;
        step(O_DA);
        resetn = 1'b1; bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
        step(O_DA);

        repeat (3) @(negedge clock);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
